// File: rtl/dwrr_req_queues.sv
// Per-requestor packet FIFOs feeding a DWRR arbiter: occupancy drives reqs, grants pop and deliver.
// Optional macro DWRR_OUT_REG_EN registers the delivery outputs (one cycle after the grant).
module dwrr_req_queues #(
   parameter int NUM_REQS = 4,
   parameter int DEPTH    = 4,
   parameter int DWID     = 8,
   parameter int IDWID    = $clog2(NUM_REQS)
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                push,
   input  logic [IDWID-1:0]    push_id,
   input  logic [DWID-1:0]     push_data,
   output logic                push_ready,
   output logic [NUM_REQS-1:0] full,
   output logic [NUM_REQS-1:0] reqs,
   input  logic [NUM_REQS-1:0] gnt,
   output logic                out_valid,
   output logic [IDWID-1:0]    out_id,
   output logic [DWID-1:0]     out_data,
   output logic                gnt_err
);

   localparam int PW = $clog2(DEPTH);
   localparam int CW = PW + 1;

   logic [DWID-1:0]     mem_q    [NUM_REQS][DEPTH];
   logic [DWID-1:0]     mem_d    [NUM_REQS][DEPTH];
   logic [PW-1:0]       rd_ptr_q [NUM_REQS];
   logic [PW-1:0]       rd_ptr_d [NUM_REQS];
   logic [PW-1:0]       wr_ptr_q [NUM_REQS];
   logic [PW-1:0]       wr_ptr_d [NUM_REQS];
   logic [CW-1:0]       count_q  [NUM_REQS];
   logic [CW-1:0]       count_d  [NUM_REQS];
   logic [NUM_REQS-1:0] empty;
   logic [NUM_REQS-1:0] push_sel;
   logic [NUM_REQS-1:0] pop_sel;
   logic [IDWID-1:0]    gnt_idx;
   logic                gnt_any;
   logic                gnt_multi;
   logic                pop_ok;
   logic                push_ok;
   logic                gnt_err_c;
   logic [DWID-1:0]     head_data;

   // reqs/full come only from registered counts, so gnt never loops back into reqs.
   always_comb begin
      for (int i = 0; i < NUM_REQS; i++) begin
         empty[i] = (count_q[i] == '0);
         full[i]  = (count_q[i] == CW'(DEPTH));
      end
      reqs       = ~empty;
      push_ready = ~full[push_id];
   end

   always_comb begin
      gnt_idx = '0;
      for (int i = 0; i < NUM_REQS; i++) begin
         if (gnt[i]) gnt_idx = IDWID'(i);
      end
      gnt_any   = |gnt;
      gnt_multi = ((gnt & (gnt - NUM_REQS'(1))) != '0);
      pop_ok    = ~rst & gnt_any & ~gnt_multi & ~empty[gnt_idx];
      gnt_err_c = ~rst & gnt_any & ~pop_ok;
      push_ok   = ~rst & push & ~full[push_id];
      push_sel  = push_ok ? (NUM_REQS'(1) << push_id) : '0;
      pop_sel   = pop_ok  ? gnt : '0;
      head_data = mem_q[gnt_idx][rd_ptr_q[gnt_idx]];
   end

   always_comb begin
      mem_d = mem_q;
      if (push_ok) mem_d[push_id][wr_ptr_q[push_id]] = push_data;
      for (int i = 0; i < NUM_REQS; i++) begin
         rd_ptr_d[i] = rd_ptr_q[i];
         wr_ptr_d[i] = wr_ptr_q[i];
         count_d[i]  = count_q[i];
         if (push_sel[i]) wr_ptr_d[i] = wr_ptr_q[i] + PW'(1);
         if (pop_sel[i])  rd_ptr_d[i] = rd_ptr_q[i] + PW'(1);
         if (push_sel[i] && !pop_sel[i])      count_d[i] = count_q[i] + CW'(1);
         else if (pop_sel[i] && !push_sel[i]) count_d[i] = count_q[i] - CW'(1);
      end
   end

   // Storage is deliberately not reset; counts alone define what is valid.
   always_ff @(posedge clk) begin
      mem_q <= mem_d;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < NUM_REQS; i++) begin
            rd_ptr_q[i] <= '0;
            wr_ptr_q[i] <= '0;
            count_q[i]  <= '0;
         end
      end else begin
         rd_ptr_q <= rd_ptr_d;
         wr_ptr_q <= wr_ptr_d;
         count_q  <= count_d;
      end
   end

`ifdef DWRR_OUT_REG_EN
   logic             out_valid_q, out_valid_d;
   logic [IDWID-1:0] out_id_q, out_id_d;
   logic [DWID-1:0]  out_data_q, out_data_d;
   logic             gnt_err_q, gnt_err_d;

   always_comb begin
      out_valid_d = pop_ok;
      gnt_err_d   = gnt_err_c;
      out_id_d    = pop_ok ? gnt_idx : out_id_q;
      out_data_d  = pop_ok ? head_data : out_data_q;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         out_valid_q <= 1'b0;
         out_id_q    <= '0;
         out_data_q  <= '0;
         gnt_err_q   <= 1'b0;
      end else begin
         out_valid_q <= out_valid_d;
         out_id_q    <= out_id_d;
         out_data_q  <= out_data_d;
         gnt_err_q   <= gnt_err_d;
      end
   end

   assign out_valid = out_valid_q;
   assign out_id    = out_id_q;
   assign out_data  = out_data_q;
   assign gnt_err   = gnt_err_q;
`else
   assign out_valid = pop_ok;
   assign out_id    = pop_ok ? gnt_idx : '0;
   assign out_data  = pop_ok ? head_data : '0;
   assign gnt_err   = gnt_err_c;
`endif

endmodule

// File: tb/tb_dwrr_req_queues.sv
// Directed bench for dwrr_req_queues in its default build (combinational delivery outputs).
module tb_dwrr_req_queues;

   logic       clk;
   logic       rst;
   logic       push;
   logic [1:0] push_id;
   logic [7:0] push_data;
   logic       push_ready;
   logic [3:0] full;
   logic [3:0] reqs;
   logic [3:0] gnt;
   logic       out_valid;
   logic [1:0] out_id;
   logic [7:0] out_data;
   logic       gnt_err;

   int n_checks = 0;
   int n_fail   = 0;

   dwrr_req_queues #(.NUM_REQS(4), .DEPTH(4), .DWID(8)) dut (
      .clk        (clk),
      .rst        (rst),
      .push       (push),
      .push_id    (push_id),
      .push_data  (push_data),
      .push_ready (push_ready),
      .full       (full),
      .reqs       (reqs),
      .gnt        (gnt),
      .out_valid  (out_valid),
      .out_id     (out_id),
      .out_data   (out_data),
      .gnt_err    (gnt_err)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_push(input logic [1:0] id, input logic [7:0] d);
      push = 1'b1; push_id = id; push_data = d;
      tick();
      push = 1'b0;
   endtask

   task automatic test_reset();
      rst = 1'b1; gnt = 4'b1000; push = 1'b1; push_id = 2'd3; push_data = 8'hEE;
      @(negedge clk);
      n_checks++; if (gnt_err !== 1'b0) begin n_fail++; $display("FAIL rst_gnt_err: got %b want 0", gnt_err); end
      n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL rst_out_valid: got %b want 0", out_valid); end
      tick();
      rst = 1'b0; push = 1'b0; gnt = 4'b0000;
      @(negedge clk);
      n_checks++; if (reqs !== 4'b0000) begin n_fail++; $display("FAIL rst_reqs: got %b want 0000", reqs); end
      n_checks++; if (full !== 4'b0000) begin n_fail++; $display("FAIL rst_full: got %b want 0000", full); end
      n_checks++; if (push_ready !== 1'b1) begin n_fail++; $display("FAIL rst_push_ready: got %b want 1", push_ready); end
      n_checks++; if (out_valid !== 1'b0 || gnt_err !== 1'b0) begin n_fail++; $display("FAIL rst_idle_out: valid %b err %b want 0 0", out_valid, gnt_err); end
      n_checks++; if (out_data !== 8'h00 || out_id !== 2'd0) begin n_fail++; $display("FAIL rst_idle_data: data %h id %0d want 00 0", out_data, out_id); end
      tick();
   endtask

   task automatic test_fifo_order();
      logic [7:0] exp_d [3] = '{8'h11, 8'h22, 8'h33};
      push = 1'b1; push_id = 2'd2; push_data = 8'h11;
      @(negedge clk);
      n_checks++; if (reqs !== 4'b0000) begin n_fail++; $display("FAIL fifo_reqs_same_cycle: got %b want 0000", reqs); end
      tick();
      push_data = 8'h22;
      @(negedge clk);
      n_checks++; if (reqs !== 4'b0100) begin n_fail++; $display("FAIL fifo_reqs_next_cycle: got %b want 0100", reqs); end
      tick();
      push_data = 8'h33;
      tick();
      push = 1'b0; gnt = 4'b0100;
      for (int k = 0; k < 3; k++) begin
         @(negedge clk);
         n_checks++; if (out_valid !== 1'b1 || out_id !== 2'd2) begin n_fail++; $display("FAIL fifo_valid_id[%0d]: valid %b id %0d want 1 2", k, out_valid, out_id); end
         n_checks++; if (out_data !== exp_d[k]) begin n_fail++; $display("FAIL fifo_data[%0d]: got %h want %h", k, out_data, exp_d[k]); end
         tick();
      end
      gnt = 4'b0000;
      @(negedge clk);
      n_checks++; if (reqs !== 4'b0000) begin n_fail++; $display("FAIL fifo_reqs_drained: got %b want 0000", reqs); end
      n_checks++; if (out_valid !== 1'b0 || out_data !== 8'h00) begin n_fail++; $display("FAIL fifo_idle_out: valid %b data %h want 0 00", out_valid, out_data); end
      tick();
   endtask

   task automatic test_full();
      logic [7:0] exp_d [3] = '{8'hA1, 8'hA2, 8'hA3};
      do_push(2'd1, 8'hA0);
      do_push(2'd1, 8'hA1);
      do_push(2'd1, 8'hA2);
      do_push(2'd1, 8'hA3);
      push_id = 2'd1;
      @(negedge clk);
      n_checks++; if (full !== 4'b0010) begin n_fail++; $display("FAIL full_flag: got %b want 0010", full); end
      n_checks++; if (push_ready !== 1'b0) begin n_fail++; $display("FAIL full_push_ready_q1: got %b want 0", push_ready); end
      push_id = 2'd0;
      #1;
      n_checks++; if (push_ready !== 1'b1) begin n_fail++; $display("FAIL full_push_ready_q0: got %b want 1", push_ready); end
      tick();
      push = 1'b1; push_id = 2'd1; push_data = 8'hA4; gnt = 4'b0010;
      @(negedge clk);
      n_checks++; if (out_valid !== 1'b1 || out_data !== 8'hA0) begin n_fail++; $display("FAIL full_pop_head: valid %b data %h want 1 a0", out_valid, out_data); end
      tick();
      push = 1'b0;
      @(negedge clk);
      n_checks++; if (full !== 4'b0000 || reqs !== 4'b0010) begin n_fail++; $display("FAIL full_after_drop: full %b reqs %b want 0000 0010", full, reqs); end
      for (int k = 0; k < 3; k++) begin
         n_checks++; if (out_data !== exp_d[k]) begin n_fail++; $display("FAIL full_drain[%0d]: got %h want %h", k, out_data, exp_d[k]); end
         tick();
         @(negedge clk);
      end
      gnt = 4'b0000;
      #1;
      n_checks++; if (reqs !== 4'b0000 || gnt_err !== 1'b0) begin n_fail++; $display("FAIL full_dropped_absent: reqs %b err %b want 0000 0", reqs, gnt_err); end
      tick();
   endtask

   task automatic test_illegal();
      do_push(2'd0, 8'h55);
      do_push(2'd1, 8'h66);
      gnt = 4'b0011;
      @(negedge clk);
      n_checks++; if (gnt_err !== 1'b1) begin n_fail++; $display("FAIL ill_multi_err: got %b want 1", gnt_err); end
      n_checks++; if (out_valid !== 1'b0 || out_data !== 8'h00) begin n_fail++; $display("FAIL ill_multi_out: valid %b data %h want 0 00", out_valid, out_data); end
      tick();
      gnt = 4'b1000;
      @(negedge clk);
      n_checks++; if (reqs !== 4'b0011) begin n_fail++; $display("FAIL ill_no_pop: reqs %b want 0011", reqs); end
      n_checks++; if (gnt_err !== 1'b1 || out_valid !== 1'b0) begin n_fail++; $display("FAIL ill_empty_err: err %b valid %b want 1 0", gnt_err, out_valid); end
      tick();
      gnt = 4'b0000;
      @(negedge clk);
      n_checks++; if (gnt_err !== 1'b0) begin n_fail++; $display("FAIL ill_idle_err: got %b want 0", gnt_err); end
      tick();
      gnt = 4'b0001;
      @(negedge clk);
      n_checks++; if (out_data !== 8'h55 || out_id !== 2'd0) begin n_fail++; $display("FAIL ill_pop_q0: data %h id %0d want 55 0", out_data, out_id); end
      tick();
      gnt = 4'b0010;
      @(negedge clk);
      n_checks++; if (out_data !== 8'h66 || out_id !== 2'd1) begin n_fail++; $display("FAIL ill_pop_q1: data %h id %0d want 66 1", out_data, out_id); end
      tick();
      gnt = 4'b0000;
      @(negedge clk);
      n_checks++; if (reqs !== 4'b0000) begin n_fail++; $display("FAIL ill_drained: reqs %b want 0000", reqs); end
      tick();
   endtask

   task automatic test_back_to_back();
      do_push(2'd3, 8'h70);
      push = 1'b1; push_id = 2'd3; push_data = 8'h71; gnt = 4'b1000;
      @(negedge clk);
      n_checks++; if (out_data !== 8'h70 || out_id !== 2'd3) begin n_fail++; $display("FAIL b2b_first: data %h id %0d want 70 3", out_data, out_id); end
      tick();
      push = 1'b0;
      @(negedge clk);
      n_checks++; if (reqs !== 4'b1000) begin n_fail++; $display("FAIL b2b_count_kept: reqs %b want 1000", reqs); end
      n_checks++; if (out_valid !== 1'b1 || out_data !== 8'h71) begin n_fail++; $display("FAIL b2b_second: valid %b data %h want 1 71", out_valid, out_data); end
      tick();
      gnt = 4'b0000;
      @(negedge clk);
      n_checks++; if (reqs !== 4'b0000) begin n_fail++; $display("FAIL b2b_drained: reqs %b want 0000", reqs); end
      tick();
   endtask

   task automatic test_integration();
      logic [1:0] exp_id [8] = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0, 2'd1, 2'd2, 2'd3};
      logic [7:0] exp_d  [8] = '{8'h00, 8'h10, 8'h20, 8'h30, 8'h01, 8'h11, 8'h21, 8'h31};
      int last = 3;
      int got  = 0;
      int c;
      for (int s = 0; s < 2; s++) begin
         for (int q = 0; q < 4; q++) begin
            do_push(2'(q), 8'(q * 16 + s));
         end
      end
      for (int cyc = 0; cyc < 20 && got < 8; cyc++) begin
         gnt = 4'b0000;
         for (int j = 1; j <= 4; j++) begin
            c = (last + j) % 4;
            if (gnt == 4'b0000 && reqs[c]) gnt = 4'(1 << c);
         end
         @(negedge clk);
         if (gnt != 4'b0000) begin
            n_checks++; if (gnt_err !== 1'b0 || out_valid !== 1'b1) begin n_fail++; $display("FAIL integ_grant[%0d]: err %b valid %b want 0 1", got, gnt_err, out_valid); end
            n_checks++; if (out_id !== exp_id[got] || out_data !== exp_d[got]) begin n_fail++; $display("FAIL integ_pkt[%0d]: id %0d data %h want %0d %h", got, out_id, out_data, exp_id[got], exp_d[got]); end
            last = int'(out_id);
            got++;
         end
         tick();
      end
      gnt = 4'b0000;
      n_checks++; if (got != 8) begin n_fail++; $display("FAIL integ_count: delivered %0d want 8", got); end
      @(negedge clk);
      n_checks++; if (reqs !== 4'b0000) begin n_fail++; $display("FAIL integ_drained: reqs %b want 0000", reqs); end
      tick();
   endtask

   task automatic test_mid_reset();
      do_push(2'd0, 8'hC0);
      do_push(2'd0, 8'hC1);
      do_push(2'd0, 8'hC2);
      rst = 1'b1;
      @(negedge clk);
      n_checks++; if (reqs !== 4'b0001) begin n_fail++; $display("FAIL mrst_before: reqs %b want 0001", reqs); end
      tick();
      rst = 1'b0;
      @(negedge clk);
      n_checks++; if (reqs !== 4'b0000 || full !== 4'b0000) begin n_fail++; $display("FAIL mrst_after: reqs %b full %b want 0000 0000", reqs, full); end
      tick();
      do_push(2'd0, 8'hD0);
      gnt = 4'b0001;
      @(negedge clk);
      n_checks++; if (out_valid !== 1'b1 || out_data !== 8'hD0) begin n_fail++; $display("FAIL mrst_restart: valid %b data %h want 1 d0", out_valid, out_data); end
      tick();
      gnt = 4'b0000;
      do_push(2'd0, 8'hE0);
      do_push(2'd0, 8'hE1);
      do_push(2'd0, 8'hE2);
      @(negedge clk);
      n_checks++; if (full !== 4'b0000) begin n_fail++; $display("FAIL mrst_three: full %b want 0000", full); end
      tick();
      do_push(2'd0, 8'hE3);
      @(negedge clk);
      n_checks++; if (full !== 4'b0001) begin n_fail++; $display("FAIL mrst_four: full %b want 0001", full); end
      tick();
   endtask

   initial begin
      rst = 1'b1; push = 1'b0; push_id = 2'd0; push_data = 8'h00; gnt = 4'b0000;
      test_reset();
      test_fifo_order();
      test_full();
      test_illegal();
      test_back_to_back();
      test_integration();
      test_mid_reset();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/dwrr_req_queues.md
# dwrr_req_queues

Requestor-side companion to the deficit weighted round-robin arbiter. It holds NUM_REQS independent per-requestor packet FIFOs and drives the arbiter's `reqs` vector from queue occupancy. On each grant it consumes the arbiter's `gnt` vector, pops the granted queue's head packet and presents it on a single output port. It sits between the packet producers and the shared link: producers push here, the arbiter grants, and this block delivers the granted packet.

## Interface
- `NUM_REQS`, 4, number of requestor queues; must match the arbiter.
- `DEPTH`, 4, entries per queue; power of two, ≥2.
- `DWID`, 8, packet payload width in bits.
- `IDWID`, `$clog2(NUM_REQS)`, queue index width.
- `clk` input 1: single clock; all state updates on the rising edge.
- `rst` input 1: synchronous, active-high reset.
- `push` input 1: producer write strobe.
- `push_id` input IDWID: target queue for `push`.
- `push_data` input DWID: payload to enqueue.
- `push_ready` output 1: `~full[push_id]`, combinational.
- `full` output NUM_REQS: per-queue full flags.
- `reqs` output NUM_REQS: `reqs[i] = ~empty[i]`; connects to the arbiter `reqs`.
- `gnt` input NUM_REQS: the arbiter grant vector; legal values are one-hot or zero.
- `out_valid` output 1: a packet is delivered this cycle.
- `out_id` output IDWID: source queue of the delivered packet.
- `out_data` output DWID: delivered payload.
- `gnt_err` output 1: pulses on an illegal grant.

## Operation
- Storage: NUM_REQS × DEPTH × DWID array.
- Per-queue state: read pointer and write pointer, each `$clog2(DEPTH)` bits, wrapping modulo DEPTH.
- Per-queue count: `$clog2(DEPTH)+1` bits.
- `empty[i] = (count[i]==0)`; `full[i] = (count[i]==DEPTH)`.
- Push accepted iff `push & ~full[push_id]`. The write pointer and count then increment. A push to a full queue is dropped with no state change, even if that queue pops in the same cycle.
- Legal grant: `gnt` is one-hot with bit i set and `~empty[i]`. A legal grant pops queue i: read pointer increments, count decrements, and the head entry is delivered.
- Illegal grant, either of:
  - more than one `gnt` bit set;
  - a single bit set for an empty queue.
  
  Response: no pop, no delivery, `gnt_err`=1 for that cycle.
- `gnt`=0: idle, no effect.
- Simultaneous push and pop on the same queue: both take effect, and the count is unchanged. A pop on queue i does not create room for a same-cycle push to queue i.
- A push to an empty queue raises `reqs[i]` in the next cycle, never in the same cycle.
- Arithmetic: pointers wrap naturally at DEPTH. The count never exceeds DEPTH and never underflows, guaranteed by the accept and pop rules above.
- No FSM beyond the per-queue counters. The block is stateless with respect to arbitration policy; quantum and deficit handling belong to the arbiter.

## Timing
- Reset (`rst`=1 at an edge):
  - all pointers and counts return to 0, so `reqs`=0 and `full`=0;
  - `out_valid`=0, `out_id`=0, `out_data`=0, `gnt_err`=0;
  - `push_ready`=1.
- Any push or grant in a reset cycle is ignored.
- Storage array contents are not reset.
- Reset mid-operation discards all queued packets. The next cycle behaves as after power-up.
- `reqs` and `full` are pure functions of registered counts and are stable for the whole cycle. This matters because the arbiter's `gnt` depends combinationally on `reqs`; the block has no combinational path from `gnt` to `reqs`.
- Delivery latency: see Configuration.

## Configuration
- `DWRR_OUT_REG_EN` defined:
  - `out_valid`, `out_id`, `out_data` and `gnt_err` are registered and appear one cycle after the grant cycle;
  - all four reset to 0;
  - `out_data` holds its last value while `out_valid`=0.
- `DWRR_OUT_REG_EN` undefined:
  - the outputs are combinational from `gnt` and the queue heads, in the same cycle as the grant;
  - `out_data`/`out_id` are 0 when `out_valid`=0.
- Queue and pop behaviour is identical in both builds.

## Test plan
- **Reset, then idle:** `reqs`=0, `full`=0, `push_ready`=1, `out_valid`=0, `gnt_err`=0.
- **FIFO order:** push 0x11, 0x22, 0x33 to queue 2, then `gnt`=4'b0100 for three cycles → `reqs[2]` first rises the cycle after the first push; `out_id`=2, `out_data` 0x11, 0x22, 0x33 in order (same cycle, or +1 with `DWRR_OUT_REG_EN`); `reqs[2]` falls after the third pop.
- **Full queue:** push DEPTH packets to queue 1 → `full[1]`=1. A further push with `gnt[1]` in the same cycle → push dropped, count = DEPTH-1 afterwards.
- **Illegal grants:** `gnt`=4'b0011 with queues 0 and 1 non-empty → no pop, `gnt_err` pulses. `gnt`=4'b1000 with queue 3 empty → `gnt_err` pulses.
- **Integration:** connect to the arbiter with queues 0–3 preloaded → packets drain in round-robin order, with no `gnt_err` and no lost packets.
- **Mid-stream reset:** `rst` asserted while queue 0 holds 3 packets → `reqs`=0 next cycle; a subsequent push/pop restarts at pointer 0.
